kb_cmd_queue: RTL and testbench

Sits between the PS/2 keyboard decoder and the game/VGA controller in the 25 MHz domain. Consumes completed scancode bytes with their strobe and tracks the E0 (extended) and F0 (break) prefixes. Translates recognised make codes into 3-bit game commands, suppresses typematic auto-repeat, and buffers commands in a small FIFO. The game controller pops one command per game tick.

---
 rtl/kb_cmd_queue.sv | 190 +++++++++++++++++++
 tb/tb_kb_cmd_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : kb_cmd_queue
// Purpose  : Turns PS/2 scancode bytes into 3-bit game commands. Tracks the
//            E0/F0 prefixes, drops typematic repeats using a per-command
//            "held" level, and buffers the commands in a small FIFO that the
//            game controller pops once per game tick.
// Ports    : CLK       - 25 MHz system clock
//            ARST_L    - asynchronous active-low reset
//            KBCODE    - scancode byte, qualified by KBSTROBE
//            KBSTROBE  - one-cycle pulse per completed byte
//            CMD_POP   - consumer takes the head entry (ignored when empty)
//            OVF_CLR   - clears the sticky overflow flag
//            CMD       - registered head-of-queue command, 0 when empty
//            CMD_VALID - registered queue non-empty flag
//            HELD      - bit k-1 is 1 while the key for command k is down
//            OVF       - sticky flag, a push was dropped on a full queue
// Revision : 1.0 - initial release
// ============================================================================
module kb_cmd_queue #(
  parameter int DEPTH      = 4,
  parameter int PREFIX_TMO = 250000
) (
  input  logic       CLK,
  input  logic       ARST_L,
  input  logic [7:0] KBCODE,
  input  logic       KBSTROBE,
  input  logic       CMD_POP,
  input  logic       OVF_CLR,
  output logic [2:0] CMD,
  output logic       CMD_VALID,
  output logic [6:0] HELD,
  output logic       OVF
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_TW = ($clog2(PREFIX_TMO) > 0) ? $clog2(PREFIX_TMO) : 1;
  localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(PREFIX_TMO - 1);
  localparam logic [c_TW-1:0] c_TMO_ONE  = c_TW'(1);
  localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(DEPTH);
  localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
  localparam logic [7:0]      c_PFX_EXT  = 8'hE0;
  localparam logic [7:0]      c_PFX_BRK  = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  // Non-extended codes; the arrow codes only count when E0-prefixed.
  function automatic logic [2:0] f_map_std(input logic [7:0] code);
    case (code)
      8'h29:   return 3'd5;
      8'h5A:   return 3'd6;
      8'h1B:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] f_map_ext(input logic [7:0] code);
    case (code)
      8'h75:   return 3'd1;
      8'h72:   return 3'd2;
      8'h6B:   return 3'd3;
      8'h74:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  state_t          r_state, w_state_nxt, w_state_eff;
  logic [c_TW-1:0] r_tmo, w_tmo_nxt;
  logic [6:0]      r_held, w_held_nxt;
  logic [2:0]      w_make_cmd, w_brk_cmd;
  logic [6:0]      w_make_oh, w_brk_oh;
  logic            w_timed_out, w_push;

  logic [2:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [c_AW:0]   r_count, w_cnt_nxt;
  logic            w_pop, w_full, w_wr, w_drop;
  logic [2:0]      r_cmd, w_head_nxt;
  logic            r_valid, r_ovf;

  // ---------------------------------------------------------------- parser
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
      r_held  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= w_tmo_nxt;
      r_held  <= w_held_nxt;
    end
  end

  always_comb begin
    w_make_cmd  = 3'd0;
    w_brk_cmd   = 3'd0;
    // An expired prefix is abandoned on the same edge, so a byte arriving
    // exactly then is decoded as if no prefix had been seen.
    w_timed_out = (r_state != S_IDLE) && (r_tmo == c_TMO_LAST);
    w_state_eff = w_timed_out ? S_IDLE : r_state;
    w_state_nxt = w_state_eff;
    if (KBSTROBE) begin
      case (w_state_eff)
        S_IDLE: begin
          if (KBCODE == c_PFX_EXT)      w_state_nxt = S_EXT;
          else if (KBCODE == c_PFX_BRK) w_state_nxt = S_BRK;
          else                          w_make_cmd  = f_map_std(KBCODE);
        end
        S_EXT: begin
          w_state_nxt = S_IDLE;
          if (KBCODE == c_PFX_BRK) w_state_nxt = S_EXT_BRK;
          else                     w_make_cmd  = f_map_ext(KBCODE);
        end
        S_BRK: begin
          w_state_nxt = S_IDLE;
          w_brk_cmd   = f_map_std(KBCODE);
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_brk_cmd   = f_map_ext(KBCODE);
        end
      endcase
    end
    // Counter only runs while a prefix is pending; any byte restarts it.
    if (KBSTROBE || (w_state_nxt == S_IDLE)) w_tmo_nxt = '0;
    else                                     w_tmo_nxt = r_tmo + c_TMO_ONE;

    w_make_oh  = (w_make_cmd != 3'd0) ? (7'd1 << (w_make_cmd - 3'd1)) : 7'd0;
    w_brk_oh   = (w_brk_cmd  != 3'd0) ? (7'd1 << (w_brk_cmd  - 3'd1)) : 7'd0;
    // A make for a key already held is a typematic repeat: no push.
    w_push     = |(w_make_oh & ~r_held);
    w_held_nxt = (r_held | w_make_oh) & ~w_brk_oh;
  end

  // ------------------------------------------------------------------ FIFO
  always_comb begin
    w_pop    = CMD_POP && (r_count != '0);
    w_full   = (r_count == c_DEPTH);
    w_wr     = w_push && (!w_full || w_pop);
    w_drop   = w_push && w_full && !w_pop;
    w_rd_nxt = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;
    case ({w_wr, w_pop})
      2'b10:   w_cnt_nxt = r_count + c_CNT_ONE;
      2'b01:   w_cnt_nxt = r_count - c_CNT_ONE;
      default: w_cnt_nxt = r_count;
    endcase
    // The next head may be the entry being written this very cycle
    // (queue empty, or draining its last entry while a push arrives).
    if (w_cnt_nxt == '0)                     w_head_nxt = 3'd0;
    else if (w_wr && (w_rd_nxt == r_wr_ptr)) w_head_nxt = w_make_cmd;
    else                                     w_head_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 3'd0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_cmd    <= 3'd0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_make_cmd;
        r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
      end
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_cmd    <= w_head_nxt;
      r_valid  <= (w_cnt_nxt != '0);
      // Setting wins over a simultaneous clear.
      if (w_drop)       r_ovf <= 1'b1;
      else if (OVF_CLR) r_ovf <= 1'b0;
    end
  end

  assign CMD       = r_cmd;
  assign CMD_VALID = r_valid;
  assign HELD      = r_held;
  assign OVF       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_kb_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_kb_cmd_queue
// Purpose  : Self-checking bench for kb_cmd_queue. A behavioural model keeps
//            prefix flags, a held-key mask and a queue of commands; every
//            cycle the DUT outputs are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kb_cmd_queue;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       CLK = 1'b0;
  logic       ARST_L = 1'b1;
  logic [7:0] KBCODE = 8'h00;
  logic       KBSTROBE = 1'b0;
  logic       CMD_POP = 1'b0;
  logic       OVF_CLR = 1'b0;
  logic [2:0] CMD;
  logic       CMD_VALID;
  logic [6:0] HELD;
  logic       OVF;

  kb_cmd_queue #(.DEPTH(DEPTH), .PREFIX_TMO(TMO)) u_dut (
    .CLK       (CLK),
    .ARST_L    (ARST_L),
    .KBCODE    (KBCODE),
    .KBSTROBE  (KBSTROBE),
    .CMD_POP   (CMD_POP),
    .OVF_CLR   (OVF_CLR),
    .CMD       (CMD),
    .CMD_VALID (CMD_VALID),
    .HELD      (HELD),
    .OVF       (OVF)
  );

  always #20 CLK = ~CLK;

  int         n_assert = 0;
  int         n_fail   = 0;

  // Reference model state
  int         q[$];
  logic [6:0] m_held = '0;
  bit         m_ovf = 0, m_e0 = 0, m_f0 = 0;
  int         m_cyc = 0, m_last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_assert++;
    assert (obs === 32'(exp))
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int map_std(input logic [7:0] c);
    case (c)
      8'h29: return 5;
      8'h5A: return 6;
      8'h1B: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic int map_ext(input logic [7:0] c);
    case (c)
      8'h75: return 1;
      8'h72: return 2;
      8'h6B: return 3;
      8'h74: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_held = '0;
    m_ovf = 0; m_e0 = 0; m_f0 = 0;
  endtask

  // Predict the effect of the coming clock edge.
  task automatic model_edge(input bit stb, input logic [7:0] code,
                            input bit pop, input bit clr);
    int  k, push_k;
    bit  popeff, full;
    push_k = 0;
    m_cyc++;
    if (stb) begin
      // A prefix older than TMO edges has been abandoned.
      if ((m_e0 || m_f0) && (m_cyc - m_last >= TMO)) begin
        m_e0 = 0; m_f0 = 0;
      end
      m_last = m_cyc;
      if (!m_e0 && !m_f0) begin
        if (code == 8'hE0)      m_e0 = 1;
        else if (code == 8'hF0) m_f0 = 1;
        else begin
          k = map_std(code);
          if (k != 0 && !m_held[k-1]) begin m_held[k-1] = 1'b1; push_k = k; end
        end
      end else if (m_e0 && !m_f0) begin
        if (code == 8'hF0) m_f0 = 1;
        else begin
          k = map_ext(code);
          if (k != 0 && !m_held[k-1]) begin m_held[k-1] = 1'b1; push_k = k; end
          m_e0 = 0;
        end
      end else begin
        k = m_e0 ? map_ext(code) : map_std(code);
        if (k != 0) m_held[k-1] = 1'b0;
        m_e0 = 0; m_f0 = 0;
      end
    end
    full   = (q.size() == DEPTH);
    popeff = pop && (q.size() > 0);
    if (popeff) void'(q.pop_front());
    if (push_k != 0 && full && !popeff) m_ovf = 1;
    else begin
      if (push_k != 0) q.push_back(push_k);
      if (clr) m_ovf = 0;
    end
  endtask

  task automatic check_outputs();
    chk("cmd",   CMD,       (q.size() > 0) ? q[0] : 0);
    chk("valid", CMD_VALID, (q.size() > 0) ? 1 : 0);
    chk("held",  HELD,      int'(m_held));
    chk("ovf",   OVF,       int'(m_ovf));
  endtask

  task automatic step(input bit stb, input logic [7:0] code,
                      input bit pop, input bit clr);
    KBSTROBE = stb; KBCODE = code; CMD_POP = pop; OVF_CLR = clr;
    model_edge(stb, code, pop, clr);
    @(posedge CLK); #1;
    KBSTROBE = 1'b0; CMD_POP = 1'b0; OVF_CLR = 1'b0;
    check_outputs();
  endtask

  task automatic key(input logic [7:0] code);
    step(1'b1, code, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_cmd"},   CMD,       0);
    chk({tag, "_valid"}, CMD_VALID, 0);
    chk({tag, "_held"},  HELD,      0);
    chk({tag, "_ovf"},   OVF,       0);
  endtask

  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hF0, 8'h29, 8'h5A, 8'h1B,
                            8'h75, 8'h72, 8'h6B, 8'h74, 8'h12, 8'h00};

  initial begin
    // Power-on reset
    #5 ARST_L = 1'b0;
    #1 zero_check("reset");
    @(posedge CLK); @(posedge CLK); #1;
    ARST_L = 1'b1;
    model_reset();

    // Single make: space -> CAST
    key(8'h29);
    chk("cast_cmd", CMD, 5);
    chk("cast_held", HELD, 7'b0010000);
    pop1();
    chk("cast_pop_valid", CMD_VALID, 0);
    key(8'hF0); key(8'h29);

    // Extended make then extended break
    key(8'hE0); key(8'h75);
    chk("up_held", HELD[0], 1);
    key(8'hE0); key(8'hF0); key(8'h75);
    chk("up_cmd", CMD, 1);
    chk("up_released", HELD[0], 0);
    pop1();
    chk("up_single", CMD_VALID, 0);

    // Typematic suppression
    key(8'h5A); key(8'h5A); key(8'h5A);
    key(8'hF0); key(8'h5A);
    key(8'h5A);
    chk("reel_held", HELD[5], 1);
    pop1();
    chk("reel_second", CMD, 6);
    pop1();
    key(8'hF0); key(8'h5A);

    // Fill and overflow
    key(8'h5A); key(8'hF0); key(8'h5A);
    key(8'h29); key(8'hF0); key(8'h29);
    key(8'h1B); key(8'hF0); key(8'h1B);
    key(8'hE0); key(8'h72); key(8'hE0); key(8'hF0); key(8'h72);
    key(8'hE0); key(8'h6B); key(8'hE0); key(8'hF0); key(8'h6B);
    chk("full_ovf", OVF, 1);
    chk("full_head", CMD, 6);
    step(1'b1, 8'h5A, 1'b1, 1'b0);     // push + pop on a full queue
    chk("pushpop_ovf", OVF, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", OVF, 0);
    pop1(); pop1(); pop1(); pop1();
    pop1();                            // pop while empty
    chk("empty_pop_cmd", CMD, 0);
    key(8'hF0); key(8'h5A);

    // Prefix timeout: exactly TMO edges later the prefix is gone
    key(8'hE0); idle(TMO - 1); key(8'h75);
    chk("tmo_nopush", CMD_VALID, 0);
    key(8'h75);                        // keypad 8, unmapped
    chk("keypad_nopush", CMD_VALID, 0);
    key(8'hE0); idle(TMO - 2); key(8'h75);
    chk("tmo_edge_push", CMD, 1);
    pop1();
    key(8'hE0); key(8'hF0); key(8'h75);

    // Reset mid-sequence discards the pending prefix
    key(8'hE0); key(8'hF0);
    ARST_L = 1'b0;
    #2 zero_check("midreset");
    model_reset();
    @(posedge CLK); #1;
    ARST_L = 1'b1;
    key(8'h74);
    chk("postreset_nopush", CMD_VALID, 0);
    key(8'hE0); key(8'h74);
    chk("right_cmd", CMD, 4);
    pop1();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)],
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
